// File: rtl/axi_bridge_wb.sv
`default_nettype none
// ============================================================================
//  Module      : axi_bridge_wb
//  Description : AXI3 master that serves the I-cache refill, D-cache refill,
//                D-cache dirty-line write-back and uncached single-word
//                read/write ports. Read and write channels run as two
//                independent state machines. Completion is signalled by
//                one-cycle done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_bridge_wb #(
    parameter int ILINE_WORDS = 16,
    parameter int DLINE_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ird_req,
    input  logic [31:0]               ird_addr,
    output logic                      i_reload,
    output logic [ILINE_WORDS*32-1:0] icacheline_new,
    input  logic                      drd_req,
    input  logic [31:0]               drd_addr,
    output logic                      d_reload,
    output logic [DLINE_WORDS*32-1:0] dcacheline_new,
    input  logic                      dwr_req,
    input  logic [31:0]               dwr_addr,
    input  logic [DLINE_WORDS*32-1:0] dcacheline_old,
    output logic                      dwr_done,
    input  logic                      unrd_req,
    input  logic [31:0]               unrd_addr,
    output logic                      un_reload,
    output logic [31:0]               unrd_data,
    input  logic                      unwr_req,
    input  logic [31:0]               unwr_addr,
    input  logic [3:0]                unwr_wstrb,
    input  logic [31:0]               unwr_data,
    output logic                      unwr_done,
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [1:0]                arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [3:0]                awid,
    output logic [31:0]               awaddr,
    output logic [3:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [1:0]                awlock,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [3:0]                wid,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [3:0]                bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);
    localparam int          c_ishift = $clog2(ILINE_WORDS * 4);
    localparam int          c_dshift = $clog2(DLINE_WORDS * 4);
    localparam logic [31:0] c_imask  = ~((32'd1 << c_ishift) - 32'd1);
    localparam logic [31:0] c_dmask  = ~((32'd1 << c_dshift) - 32'd1);
    localparam logic [3:0]  c_ilen   = 4'(ILINE_WORDS - 1);
    localparam logic [3:0]  c_dlen   = 4'(DLINE_WORDS - 1);
    localparam logic [3:0]  c_id_i   = 4'd0;
    localparam logic [3:0]  c_id_d   = 4'd1;
    localparam logic [3:0]  c_id_un  = 4'd2;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2, R_DONE = 2'd3} rstate_t;
    typedef enum logic [2:0] {W_IDLE = 3'd0, W_AW = 3'd1, W_DATA = 3'd2, W_RESP = 3'd3, W_DONE = 3'd4} wstate_t;

    rstate_t     r_rstate;
    wstate_t     r_wstate;
    logic [3:0]  r_rbeat;
    logic [3:0]  r_wbeat;
    logic        w_rd_ok;
    logic        w_rd_pulse;
    logic [2:0]  w_un_size;
    logic [31:0] w_first_wdata;
    logic [31:0] w_next_wdata;
    logic        w_unused;

    // Response ids/status are not acted upon.
    assign w_unused = ^{rid, rresp, bid, bresp};

    // Uncached and D reads wait for the write side to drain (write-before-read).
    assign w_rd_ok    = (r_wstate == W_IDLE) && !dwr_req && !unwr_req;
    // The read done pulse is visible while the FSM is already idle; hold off
    // arbitration for that cycle so the finishing requester can drop req.
    assign w_rd_pulse = i_reload | d_reload | un_reload;
    assign w_first_wdata = (awid == c_id_d) ? dcacheline_old[31:0] : unwr_data;

    // Uncached write size follows the byte-strobe pattern.
    always_comb begin
        case (unwr_wstrb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_un_size = 3'b000;
            4'b0011, 4'b1100:                   w_un_size = 3'b001;
            default:                            w_un_size = 3'b010;
        endcase
    end

    // Select the write-back word that follows the current beat.
    always_comb begin
        w_next_wdata = '0;
        for (int k = 0; k < DLINE_WORDS; k++) begin
            if (int'(r_wbeat) + 1 == k) w_next_wdata = dcacheline_old[k*32 +: 32];
        end
    end

    // Read channel FSM: arbitration, AR issue, beat capture and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate       <= R_IDLE;
            r_rbeat        <= '0;
            arid           <= '0;
            araddr         <= '0;
            arlen          <= '0;
            arsize         <= 3'b010;
            arburst        <= 2'b01;
            arlock         <= '0;
            arcache        <= '0;
            arprot         <= '0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            i_reload       <= 1'b0;
            d_reload       <= 1'b0;
            un_reload      <= 1'b0;
            icacheline_new <= '0;
            dcacheline_new <= '0;
            unrd_data      <= '0;
        end else begin
            i_reload  <= 1'b0;
            d_reload  <= 1'b0;
            un_reload <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (!w_rd_pulse) begin
                        if (unrd_req && w_rd_ok) begin
                            arid     <= c_id_un;
                            araddr   <= unrd_addr;
                            arlen    <= 4'd0;
                            arvalid  <= 1'b1;
                            r_rstate <= R_AR;
                        end else if (drd_req && w_rd_ok) begin
                            arid     <= c_id_d;
                            araddr   <= drd_addr & c_dmask;
                            arlen    <= c_dlen;
                            arvalid  <= 1'b1;
                            r_rstate <= R_AR;
                        end else if (ird_req) begin
                            arid     <= c_id_i;
                            araddr   <= ird_addr & c_imask;
                            arlen    <= c_ilen;
                            arvalid  <= 1'b1;
                            r_rstate <= R_AR;
                        end
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        r_rbeat  <= '0;
                        r_rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid) begin
                        if (arid == c_id_i) begin
                            for (int k = 0; k < ILINE_WORDS; k++) begin
                                if (int'(r_rbeat) == k) icacheline_new[k*32 +: 32] <= rdata;
                            end
                        end else if (arid == c_id_d) begin
                            for (int k = 0; k < DLINE_WORDS; k++) begin
                                if (int'(r_rbeat) == k) dcacheline_new[k*32 +: 32] <= rdata;
                            end
                        end else begin
                            unrd_data <= rdata;
                        end
                        r_rbeat <= r_rbeat + 4'd1;
                        if (rlast) begin
                            rready   <= 1'b0;
                            r_rstate <= R_DONE;
                        end
                    end
                end
                R_DONE: begin
                    if (arid == c_id_i)      i_reload  <= 1'b1;
                    else if (arid == c_id_d) d_reload  <= 1'b1;
                    else                     un_reload <= 1'b1;
                    r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Write channel FSM: AW issue, W beats after AW acceptance, B wait, done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_wbeat   <= '0;
            awid      <= '0;
            awaddr    <= '0;
            awlen     <= '0;
            awsize    <= 3'b010;
            awburst   <= 2'b01;
            awlock    <= '0;
            awcache   <= '0;
            awprot    <= '0;
            awvalid   <= 1'b0;
            wid       <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            wlast     <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            dwr_done  <= 1'b0;
            unwr_done <= 1'b0;
        end else begin
            dwr_done  <= 1'b0;
            unwr_done <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (dwr_req) begin
                        awid     <= c_id_d;
                        wid      <= c_id_d;
                        awaddr   <= dwr_addr & c_dmask;
                        awlen    <= c_dlen;
                        awsize   <= 3'b010;
                        wstrb    <= 4'b1111;
                        awvalid  <= 1'b1;
                        r_wstate <= W_AW;
                    end else if (unwr_req) begin
                        awid     <= c_id_un;
                        wid      <= c_id_un;
                        awaddr   <= unwr_addr;
                        awlen    <= 4'd0;
                        awsize   <= w_un_size;
                        wstrb    <= unwr_wstrb;
                        awvalid  <= 1'b1;
                        r_wstate <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        wvalid   <= 1'b1;
                        wdata    <= w_first_wdata;
                        wlast    <= (awlen == 4'd0);
                        r_wbeat  <= '0;
                        r_wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid   <= 1'b0;
                            wlast    <= 1'b0;
                            bready   <= 1'b1;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wbeat <= r_wbeat + 4'd1;
                            wdata   <= w_next_wdata;
                            wlast   <= (r_wbeat + 4'd1 == awlen);
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (awid == c_id_d) dwr_done  <= 1'b1;
                        else                unwr_done <= 1'b1;
                        r_wstate <= W_DONE;
                    end
                end
                W_DONE:  r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_bridge_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_bridge_wb
//  Description : Directed scoreboard bench for axi_bridge_wb with a simple
//                zero-wait AXI3 slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_bridge_wb;
    localparam int IW = 16;
    localparam int DW = 8;

    logic clk, reset;
    logic ird_req, drd_req, dwr_req, unrd_req, unwr_req;
    logic [31:0] ird_addr, drd_addr, dwr_addr, unrd_addr, unwr_addr, unwr_data;
    logic [3:0]  unwr_wstrb;
    logic i_reload, d_reload, dwr_done, un_reload, unwr_done;
    logic [IW*32-1:0] icacheline_new;
    logic [DW*32-1:0] dcacheline_new, dcacheline_old;
    logic [31:0] unrd_data;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic wlast, wvalid, wready, bvalid, bready;

    axi_bridge_wb #(.ILINE_WORDS(IW), .DLINE_WORDS(DW)) dut (
        .clk(clk), .reset(reset),
        .ird_req(ird_req), .ird_addr(ird_addr), .i_reload(i_reload), .icacheline_new(icacheline_new),
        .drd_req(drd_req), .drd_addr(drd_addr), .d_reload(d_reload), .dcacheline_new(dcacheline_new),
        .dwr_req(dwr_req), .dwr_addr(dwr_addr), .dcacheline_old(dcacheline_old), .dwr_done(dwr_done),
        .unrd_req(unrd_req), .unrd_addr(unrd_addr), .un_reload(un_reload), .unrd_data(unrd_data),
        .unwr_req(unwr_req), .unwr_addr(unwr_addr), .unwr_wstrb(unwr_wstrb), .unwr_data(unwr_data),
        .unwr_done(unwr_done),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [3:0] len;} ar_t;
    typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size; logic [3:0] strb;} aw_t;
    typedef struct packed {logic [31:0] data; logic last;} w_t;

    ar_t exp_ar[$];
    aw_t exp_aw[$];
    w_t  exp_w[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_ar, t_aw, t_b, t_rlast, t1, t2, t0;
    int n_ird = 0, n_drd = 0, n_un = 0, n_dwr = 0, n_unwr = 0;
    int s_beat = -1;
    int aw_open = 0;
    logic [31:0] r_pattern = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_sig(input int w);
        case (w)
            0: return i_reload;
            1: return d_reload;
            2: return un_reload;
            3: return dwr_done;
            default: return unwr_done;
        endcase
    endfunction

    // Wait (bounded) at negedges for a done pulse; returns the cycle it was seen.
    task automatic wait_done(input int w, input string tag, output int t);
        int i;
        i = 0;
        while (!done_sig(w) && i < 300) begin
            @(negedge clk);
            i++;
        end
        check(tag, {63'd0, done_sig(w)}, 64'd1);
        t = cyc;
    endtask

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial forever begin @(posedge clk); cyc++; end

    assign arready = 1'b1;
    assign awready = 1'b1;
    assign wready  = 1'b1;
    assign rid = 4'd0; assign rresp = 2'd0; assign bid = 4'd0; assign bresp = 2'd0;

    // Read slave: zero-wait bursts of r_pattern + beat index.
    initial begin : slave_r
        int len, guard;
        bit abort;
        rvalid = 0; rlast = 0; rdata = 0;
        forever begin
            @(negedge clk);
            if (arvalid && arready && !reset) begin
                len = int'(arlen);
                abort = 0;
                @(posedge clk); #1;
                for (int k = 0; k <= len && !abort; k++) begin
                    rvalid = 1; rdata = r_pattern + k; rlast = (k == len); s_beat = k;
                    guard = 0;
                    do begin @(negedge clk); guard++; end while (!rready && !reset && guard < 200);
                    if (reset || !rready) abort = 1;
                    @(posedge clk); #1;
                end
                rvalid = 0; rlast = 0; s_beat = -1;
            end
        end
    end

    // Write response slave.
    initial begin : slave_b
        int guard;
        bvalid = 0;
        forever begin
            @(negedge clk);
            if (wvalid && wready && wlast && !reset) begin
                @(posedge clk); #1;
                bvalid = 1;
                guard = 0;
                do begin @(negedge clk); guard++; end while (!bready && !reset && guard < 200);
                t_b = cyc;
                @(posedge clk); #1;
                bvalid = 0;
            end
        end
    end

    // Channel monitors: pop the scoreboard on each handshake.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (arvalid && arready) begin
                t_ar = cyc;
                if (exp_ar.size() == 0) check("ar_unexpected", {24'd0, arid, araddr, arlen}, 64'd0);
                else check("ar", {24'd0, arid, araddr, arlen}, {24'd0, exp_ar.pop_front()});
            end
            if (awvalid && awready) begin
                t_aw = cyc;
                aw_open = 1;
                if (exp_aw.size() == 0) check("aw_unexpected", {17'd0, awid, awaddr, awlen, awsize, wstrb}, 64'd0);
                else check("aw", {17'd0, awid, awaddr, awlen, awsize, wstrb}, {17'd0, exp_aw.pop_front()});
            end
            if (wvalid && wready) begin
                check("w_after_aw", 64'(aw_open), 64'd1);
                if (exp_w.size() == 0) check("w_unexpected", {31'd0, wdata, wlast}, 64'd0);
                else check("w", {31'd0, wdata, wlast}, {31'd0, exp_w.pop_front()});
                if (wlast) aw_open = 0;
            end
            if (rvalid && rready && rlast) t_rlast = cyc;
            if (i_reload) n_ird++;
            if (d_reload) n_drd++;
            if (un_reload) n_un++;
            if (dwr_done) n_dwr++;
            if (unwr_done) n_unwr++;
        end
    end

    function automatic logic [DW*32-1:0] make_dline(input logic [31:0] base);
        logic [DW*32-1:0] l;
        for (int k = 0; k < DW; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    initial begin : main
        int i, nd0;
        reset = 1;
        ird_req = 0; drd_req = 0; dwr_req = 0; unrd_req = 0; unwr_req = 0;
        ird_addr = 0; drd_addr = 0; dwr_addr = 0; unrd_addr = 0; unwr_addr = 0;
        unwr_data = 0; unwr_wstrb = 0; dcacheline_old = '0;
        repeat (3) @(negedge clk);
        check("rst_valids", {59'd0, arvalid, awvalid, wvalid, rready, bready}, 64'd0);
        check("rst_sizes", {58'd0, arsize, awsize}, {58'd0, 3'b010, 3'b010});
        check("rst_bursts", {60'd0, arburst, awburst}, {60'd0, 2'b01, 2'b01});
        check("rst_addr_strb", {28'd0, araddr ^ awaddr, wstrb}, 64'd0);
        check("rst_lines", {62'd0, |icacheline_new, |dcacheline_new}, 64'd0);
        reset = 0;
        @(negedge clk);

        // I-cache refill, latency and line contents.
        r_pattern = 32'hA0;
        exp_ar.push_back('{4'd0, 32'h1000_0040, 4'd15});
        ird_addr = 32'h1000_0044; ird_req = 1; t0 = cyc;
        wait_done(0, "ird_done", t1);
        ird_req = 0;
        check("ird_latency", 64'(t1 - t0), 64'd19);
        for (int k = 0; k < IW; k++) check("iline_word", {32'd0, icacheline_new[k*32 +: 32]}, 64'(32'hA0 + k));
        @(negedge clk);
        check("i_reload_width", {63'd0, i_reload}, 64'd0);
        check("ird_count", 64'(n_ird), 64'd1);

        // Write-back and D refill together: write first, read after B.
        r_pattern = 32'h0C00;
        dcacheline_old = make_dline(32'hD000_0000);
        exp_aw.push_back('{4'd1, 32'h2000_0020, 4'd7, 3'b010, 4'b1111});
        for (int k = 0; k < DW; k++) exp_w.push_back('{32'hD000_0000 + k, (k == DW - 1)});
        exp_ar.push_back('{4'd1, 32'h2000_0100, 4'd7});
        dwr_addr = 32'h2000_0020; drd_addr = 32'h2000_0100; dwr_req = 1; drd_req = 1;
        fork
            begin wait_done(3, "dwr_done", t1); dwr_req = 0; end
            begin wait_done(1, "drd_done", t2); drd_req = 0; end
        join
        check("dwr_before_drd", 64'(t1 < t2), 64'd1);
        check("ar_after_b", 64'(t_ar > t_b), 64'd1);
        for (int k = 0; k < DW; k++) check("dline_word", {32'd0, dcacheline_new[k*32 +: 32]}, 64'(32'h0C00 + k));
        @(negedge clk);

        // Uncached byte write.
        exp_aw.push_back('{4'd2, 32'hBFD0_03F8, 4'd0, 3'b000, 4'b0100});
        exp_w.push_back('{32'h00AB_0000, 1'b1});
        unwr_addr = 32'hBFD0_03F8; unwr_wstrb = 4'b0100; unwr_data = 32'h00AB_0000; unwr_req = 1;
        wait_done(4, "unwr_done", t1);
        unwr_req = 0;
        check("unwr_done_after_b", 64'(t1 - t_b), 64'd1);
        @(negedge clk);

        // Uncached read wins over a simultaneous I refill.
        r_pattern = 32'h5500;
        exp_ar.push_back('{4'd2, 32'hBFD0_0004, 4'd0});
        exp_ar.push_back('{4'd0, 32'h0000_2000, 4'd15});
        unrd_addr = 32'hBFD0_0004; ird_addr = 32'h0000_2008; unrd_req = 1; ird_req = 1;
        fork
            begin wait_done(2, "unrd_done", t1); unrd_req = 0; end
            begin wait_done(0, "ird2_done", t2); ird_req = 0; end
        join
        check("unrd_first", 64'(t1 < t2), 64'd1);
        check("unrd_data", {32'd0, unrd_data}, 64'h5500);
        check("iline2_word0", {32'd0, icacheline_new[31:0]}, 64'h5500);
        check("iline2_word15", {32'd0, icacheline_new[15*32 +: 32]}, 64'h550F);
        @(negedge clk);

        // Write-back overlapping an I refill.
        r_pattern = 32'h9000;
        dcacheline_old = make_dline(32'h6600_0000);
        exp_ar.push_back('{4'd0, 32'h0000_4000, 4'd15});
        exp_aw.push_back('{4'd1, 32'h4000_0040, 4'd7, 3'b010, 4'b1111});
        for (int k = 0; k < DW; k++) exp_w.push_back('{32'h6600_0000 + k, (k == DW - 1)});
        ird_addr = 32'h0000_4000; ird_req = 1;
        i = 0;
        while (s_beat != 2 && i < 100) begin @(negedge clk); i++; end
        dwr_addr = 32'h4000_0054; dwr_req = 1;
        fork
            begin wait_done(0, "ird3_done", t1); ird_req = 0; end
            begin wait_done(3, "dwr2_done", t2); dwr_req = 0; end
        join
        check("aw_before_rlast", 64'(t_aw < t_rlast), 64'd1);
        check("iline3_word7", {32'd0, icacheline_new[7*32 +: 32]}, 64'h9007);
        @(negedge clk);

        // Reset on read beat 3 of a D refill.
        r_pattern = 32'h7000;
        exp_ar.push_back('{4'd1, 32'h3000_0040, 4'd7});
        nd0 = n_drd;
        drd_addr = 32'h3000_0044; drd_req = 1;
        i = 0;
        while (!(rvalid && rready && s_beat == 3) && i < 100) begin @(negedge clk); i++; end
        check("rst_beat3_reached", 64'(s_beat), 64'd3);
        reset = 1;
        @(negedge clk);
        check("rst_mid_valids", {62'd0, arvalid, rready}, 64'd0);
        check("rst_mid_dones", {59'd0, i_reload, d_reload, un_reload, dwr_done, unwr_done}, 64'd0);
        check("rst_mid_dline", {63'd0, |dcacheline_new}, 64'd0);
        drd_req = 0;
        @(negedge clk);
        reset = 0;
        repeat (20) @(negedge clk);
        check("rst_no_done", 64'(n_drd - nd0), 64'd0);
        check("rst_idle", {62'd0, arvalid, awvalid}, 64'd0);

        check("ar_q_empty", 64'(exp_ar.size()), 64'd0);
        check("aw_q_empty", 64'(exp_aw.size()), 64'd0);
        check("w_q_empty", 64'(exp_w.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_bridge_wb.md
Name: axi_bridge_wb

Overview:
- Parametrised AXI3 master that serves the I-cache refill, D-cache refill, D-cache dirty-line write-back and uncached single-word read/write ports of the core.
- Read and write channels run as independent FSMs, so a write-back overlaps an I-cache refill.
- Line sizes are set per cache. D-cache write-back is fully implemented as a burst write.
- Completion is signalled by one-cycle done pulses.

Parameters:
- ILINE_WORDS, 16, I-cache line length in 32-bit words; power of 2, 2..16.
- DLINE_WORDS, 8, D-cache line length in 32-bit words; power of 2, 2..16.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ird_req / ird_addr  in  1 / 32  I-cache refill request and address
- i_reload  out  1  I refill done pulse
- icacheline_new  out  ILINE_WORDS*32  I refill line
- drd_req / drd_addr  in  1 / 32  D-cache refill request and address
- d_reload  out  1  D refill done pulse
- dcacheline_new  out  DLINE_WORDS*32  D refill line
- dwr_req / dwr_addr  in  1 / 32  dirty-line write-back request and address
- dcacheline_old  in  DLINE_WORDS*32  line being written back
- dwr_done  out  1  write-back done pulse
- unrd_req / unrd_addr  in  1 / 32  uncached read request and address
- un_reload  out  1  uncached read done pulse
- unrd_data  out  32  uncached read data
- unwr_req / unwr_addr / unwr_wstrb / unwr_data  in  1 / 32 / 4 / 32  uncached write request, address, byte strobe, data
- unwr_done  out  1  uncached write done pulse
- AR channel  out  arid 4, araddr 32, arlen 4, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1; in arready 1
- R channel  in  rid 4, rdata 32, rresp 2, rlast 1, rvalid 1; out rready 1
- AW channel  out  awid 4, awaddr 32, awlen 4, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1; in awready 1
- W channel  out  wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1; in wready 1
- B channel  in  bid 4, bresp 2, bvalid 1; out bready 1

Behaviour:
- Reset values:
  - All valid/ready/last outputs 0; all done pulses 0; all line and data outputs 0.
  - Addresses 0; lengths 0; arsize and awsize 3'b010; arburst and awburst 2'b01; lock, cache, prot 0; ids 0; wstrb 0.
- Reset mid-burst aborts immediately; no done pulse is issued.
- Request protocol:
  - A requester holds req, addr and data stable until its done pulse.
  - Each done pulse is high for exactly 1 cycle.
  - A req still high in the cycle after its done pulse starts a new transaction.
- Read FSM states: R_IDLE, R_AR, R_DATA, R_DONE.
- R_IDLE arbitration, fixed priority unrd > drd > ird:
  - unrd and drd are eligible only when the write FSM is in W_IDLE and dwr_req=0 and unwr_req=0. This enforces write-before-read ordering.
  - ird is always eligible.
- R_IDLE -> R_AR on grant. Register the request:
  - arid: 0 = I, 1 = D, 2 = uncached.
  - araddr: line-aligned, low log2(N*4) bits cleared; unrd uses the raw address.
  - arlen: N-1, or 0 for uncached.
  - arvalid=1.
- R_AR: on arready, arvalid=0, rready=1, beat counter=0 -> R_DATA.
- R_DATA:
  - Each rvalid&rready beat k writes rdata to line bits [32k+:32]; uncached writes unrd_data.
  - On the rlast beat: rready=0 -> R_DONE.
  - rresp and rid are ignored.
- R_DONE: pulse the granted done output -> R_IDLE.
- Refill latency with a zero-wait slave: N+3 cycles from grant to done.
- Line outputs hold their value until the next refill of the same cache.
- Write FSM states: W_IDLE, W_AW, W_DATA, W_RESP, W_DONE. Priority dwr > unwr.
- dwr:
  - awid=1, awaddr=line-aligned dwr_addr, awlen=DLINE_WORDS-1, awsize=010, wstrb=1111.
  - Beat k sends dcacheline_old[32k+:32].
- unwr:
  - awid=2, awaddr=unwr_addr, awlen=0, wstrb=unwr_wstrb.
  - awsize: 000 for single-byte strobes, 001 for 0011 or 1100, 010 otherwise.
- W_AW: awvalid=1 until awready -> W_DATA with wvalid=1.
- W_DATA:
  - Advance the beat on wready; wlast=1 on beat awlen.
  - Final beat accepted: wvalid=0, bready=1 -> W_RESP.
- W_RESP: on bvalid, bready=0 -> W_DONE.
- W_DONE: pulse dwr_done or unwr_done -> W_IDLE.
- The write FSM never issues W data before AW is accepted.
- The two FSMs may complete in the same cycle; both done pulses assert.

Test Plan:
- ird_req, addr 0x1000_0044, ILINE_WORDS=16, slave returns 0xA0+k -> araddr 0x1000_0040, arlen 15, arid 0; icacheline_new word k = 0xA0+k; i_reload pulses once, 19 cycles after grant.
- dwr_req to 0x2000_0020 and drd_req to 0x2000_0100 raised together -> AW burst of 8 beats with wlast on beat 7; AR issued only after B handshake; dwr_done precedes d_reload.
- unwr_req, wstrb 0100, data 0x00AB0000, addr 0xBFD0_03F8 -> awsize 000, awlen 0, wstrb 0100; unwr_done one cycle after bvalid.
- unrd_req and ird_req simultaneous -> uncached AR (arid 2, arlen 0) first, un_reload, then I refill.
- ird refill in flight while dwr_req is asserted -> AW issued before the I refill's rlast; both complete correctly.
- reset asserted on read beat 3 of 8 -> arvalid, rready and all done pulses 0 next cycle; no done pulse; FSMs in idle.
